drysponge_mix128: RTL
=====================

# drysponge_mix128

Mixes one 128-bit input block plus a 4-bit domain separator into the DryGASCON capacity state C. It uses the secret X words produced by the key-schedule stage (`ksneq32`, consumed through its `cout`/`xout`/`done`) and interleaves 14 Gascon core rounds. It sits directly downstream of the key schedule and upstream of the absorb/squeeze controller, which takes the mixed C for the G function.

## Interface
- `CWIDTH`, 320: capacity width in bits; must be a multiple of 64. CW = CWIDTH/64 64-bit words.
- `XWIDTH`, 128: X width in bits; must be 4×32. XWORDS = 4, so each word index is 2 bits.
- `IWIDTH`, 128: input block width.
- `DSWIDTH`, 4: domain separator width.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset), sampled on the `clk` rising edge.
- `start` input 1: request pulse; accepted only in IDLE or DONE.
- `c_in` input CWIDTH: initial C; connects from key-schedule `cout`.
- `x_in` input XWIDTH: X words; connects from key-schedule `xout`.
- `i_in` input IWIDTH: input block.
- `ds` input DSWIDTH: domain separator.
- `c_out` input-side note: none. `c_out` output CWIDTH: mixed C. Driven from the internal C register at all times; meaningful when `done` = 1.
- `busy` output 1: high from LOAD through the last ROUND.
- `done` output 1: level, high only in DONE.

## Operation
- Padded vector P = {8'b0, ds, i_in}, 140 bits, split into NCH = 14 chunks of 2·CW = 10 bits. Chunk j = P[10j +: 10].
- MixPhi for chunk j, for each k = 0..CW-1:
  - idx = chunk[2k +: 2]
  - C[64k +: 32] ^= X[32·idx +: 32]
  - C[64k+32 +: 32] is unchanged.
- After each MixPhi, apply one Gascon core round (round input 0) to the whole C.
- FSM states:
  - **IDLE**: wait for `start`; on `start`, go to LOAD.
  - **LOAD**: latch `c_in`, `x_in` and P into registers; clear chunk counter `j` = 0; go to MIX.
  - **MIX**: C ← MixPhi(C, chunk j); assert core reset; go to ROUND.
  - **ROUND**: enable the core and hold C. When core `done` = 1: C ← core output, `j` ← j+1. If j was NCH-1, go to DONE; else go to MIX.
  - **DONE**: assert `done`; hold C. On `start`, go to LOAD (same as IDLE).
- `start` in LOAD, MIX or ROUND is ignored. There is no queuing.
- Inputs are sampled only in LOAD. Changing inputs afterwards has no effect on the current operation.
- Counter `j` is 4 bits wide and never wraps. Termination is by comparison with NCH-1.

## Timing
- Reset (`reset` = 0) forces, on the next edge:
  - state IDLE, C = 0, X = 0, P = 0, `j` = 0
  - `c_out` = 0, `busy` = 0, `done` = 0
  - core held in reset
- Reset mid-operation aborts the operation. No partial `done` is produced.
- `start` sampled high in IDLE or DONE at edge t gives LOAD during cycle t+1; `busy` rises the same cycle and `done` falls.
- Per chunk: 1 MIX cycle + R ROUND cycles, where R = core latency with ROUND_COUNT = 1.
- Total from `start` edge to `done` high = 2 + 14·(1+R) cycles.
- `done` stays high and `c_out` stays stable until the next accepted `start` or reset.
- If `start` and `reset` = 0 occur in the same cycle, reset wins.

## Structure
- Shared package `drysponge_pkg`:
  - state enum `mix_state_t` {IDLE, LOAD, MIX, ROUND, DONE}
  - localparams CW, XWORDS, NCH, PADWIDTH
  - function `mix_phi(C, X, chunk)`
- One sub-module: an instance of the existing `Gascon_Core_Round` with ROUND_COUNT(1) and round = 1'b0.
  - Its active-high reset = `!reset | (state == MIX) | (state == LOAD)`.
  - Its `en` = (state == ROUND).
- No other sub-modules.

## Test plan
- **Reset values**: hold `reset` = 0 for 3 cycles with random inputs → `c_out` = 0, `busy` = 0, `done` = 0. Release reset with no `start` → outputs stay 0.
- **All-zero mix**: `c_in` = 0, `x_in` = 0, `i_in` = 0, `ds` = 0 → `done` exactly 2+14(1+R) cycles after `start`. `c_out` equals the golden model of 14 core rounds applied to zero.
- **Index decode**: `x_in` = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, `i_in` = 128'h…E4 (chunk 0 indices 0,1,2,3,3), `c_in` = 0 → the post-MIX C of chunk 0 (probed) has words 0..4 low halves = 11111111, 22222222, 33333333, 44444444, 44444444. Final `c_out` matches the golden model.
- **Domain separator placement**: `ds` = 4'hF, all else 0 → only chunks 12 and 13 carry nonzero indices (P[131:128]). Final `c_out` matches the golden model.
- **Start while busy**: pulse `start` in cycles 5 and 20 of an operation → ignored. Single `done`, identical `c_out` to the undisturbed run.
- **Reset mid-operation and restart**: `reset` = 0 during chunk 7 → next cycle IDLE with all outputs 0. A new `start` with new vectors → correct `c_out`, unaffected by the aborted run.

Source files
------------

// File: rtl/drysponge_mix128_pkg.sv
// Shared types, sizes and the MixPhi helper for the DryGASCON capacity-mix stage.
package drysponge_pkg;

   localparam int unsigned CWIDTH_D  = 320;
   localparam int unsigned XWIDTH_D  = 128;
   localparam int unsigned IWIDTH_D  = 128;
   localparam int unsigned DSWIDTH_D = 4;

   localparam int unsigned CW       = CWIDTH_D / 64;
   localparam int unsigned XWORDS   = 4;
   localparam int unsigned CHUNKW   = 2 * CW;
   localparam int unsigned NCH      = 14;
   localparam int unsigned PADWIDTH = NCH * CHUNKW;

   typedef enum logic [2:0] {IDLE, LOAD, MIX, ROUND, DONE} mix_state_t;

   // Each 2-bit field of the chunk selects which X word is folded into the low half of C word k.
   function automatic logic [CWIDTH_D-1:0] mix_phi(input logic [CWIDTH_D-1:0] c,
                                                   input logic [XWIDTH_D-1:0] x,
                                                   input logic [CHUNKW-1:0]   chunk);
      logic [CWIDTH_D-1:0] r;
      logic [1:0]          idx;
      r = c;
      for (int unsigned k = 0; k < CW; k++) begin
         idx = chunk[2*k +: 2];
         r[64*k +: 32] = c[64*k +: 32] ^ x[32*idx +: 32];
      end
      return r;
   endfunction

endpackage

// File: rtl/drysponge_mix128_core.sv
// Gascon core: ROUND_COUNT rounds over the 5-word capacity, one round per enabled cycle.
module Gascon_Core_Round
   import drysponge_pkg::*;
#(
   parameter int unsigned ROUND_COUNT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                round,
   input  logic [CWIDTH_D-1:0] din,
   output logic [CWIDTH_D-1:0] dout,
   output logic                done
);

   logic [CWIDTH_D-1:0] st;
   logic [3:0]          cnt;

   function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [CWIDTH_D-1:0] gasconRound(input logic [CWIDTH_D-1:0] s,
                                                       input logic [3:0]          rc);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = s[63:0];    x1 = s[127:64];  x2 = s[191:128];
      x3 = s[255:192]; x4 = s[319:256];
      x2 = x2 ^ {56'b0, ~rc, rc};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
      x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 38);
      x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
      x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
      x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 40);
      return {x4, x3, x2, x1, x0};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         st   <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (en && !done) begin
         st  <= gasconRound((cnt == 4'd0) ? din : st, {3'b0, round} + cnt);
         cnt <= cnt + 4'd1;
         if (cnt == 4'(ROUND_COUNT - 1)) done <= 1'b1;
      end
   end

   assign dout = st;

endmodule

// File: rtl/drysponge_mix128.sv
// DryGASCON capacity mix: folds a 128-bit block plus domain separator into C over 14 MixPhi+round steps.
module drysponge_mix128
   import drysponge_pkg::*;
#(
   parameter int unsigned CWIDTH  = 320,
   parameter int unsigned XWIDTH  = 128,
   parameter int unsigned IWIDTH  = 128,
   parameter int unsigned DSWIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CWIDTH-1:0]  c_in,
   input  logic [XWIDTH-1:0]  x_in,
   input  logic [IWIDTH-1:0]  i_in,
   input  logic [DSWIDTH-1:0] ds,
   output logic [CWIDTH-1:0]  c_out,
   output logic               busy,
   output logic               done
);

   mix_state_t            state, nextState;
   logic [CWIDTH-1:0]     cReg;
   logic [XWIDTH-1:0]     xReg;
   logic [PADWIDTH-1:0]   pReg;
   logic [3:0]            j;
   logic [CWIDTH-1:0]     coreOut;
   logic                  coreDone;
   logic                  coreRst;
   logic                  coreEn;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: if (start) nextState = LOAD;
         LOAD:       nextState = MIX;
         MIX:        nextState = ROUND;
         ROUND:      if (coreDone) nextState = (j == 4'(NCH - 1)) ? DONE : MIX;
         default:    nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cReg <= '0;
         xReg <= '0;
         pReg <= '0;
         j    <= '0;
      end else begin
         case (state)
            LOAD: begin
               cReg <= c_in;
               xReg <= x_in;
               pReg <= {{(PADWIDTH - DSWIDTH - IWIDTH){1'b0}}, ds, i_in};
               j    <= '0;
            end
            MIX:   cReg <= mix_phi(cReg, xReg, pReg[CHUNKW*j +: CHUNKW]);
            ROUND: if (coreDone) begin
               cReg <= coreOut;
               j    <= j + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Core restarts on every MIX so each chunk gets exactly one fresh round from the new C.
   assign coreRst = !reset | (state == MIX) | (state == LOAD);
   assign coreEn  = (state == ROUND);

   Gascon_Core_Round #(.ROUND_COUNT(1)) uCore (
      .clk   (clk),
      .rst   (coreRst),
      .en    (coreEn),
      .round (1'b0),
      .din   (cReg),
      .dout  (coreOut),
      .done  (coreDone)
   );

   assign c_out = cReg;
   assign busy  = (state == LOAD) || (state == MIX) || (state == ROUND);
   assign done  = (state == DONE);

endmodule
